azadi_clkdiv_bank: RTL and testbench

AZADI_CLKDIV_BANK -- requirements
Module: azadi_clkdiv_bank

---
 rtl/azadi_clkdiv_bank.sv | 95 +++++++++
 tb/tb_azadi_clkdiv_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/azadi_clkdiv_bank.sv
// Bank of independent programmable clock dividers with glitch-free divisor
// updates, per-channel enables and a global phase-align strobe.
//
// Ports:
//   clock      single clock, all state on its rising edge
//   reset_i    synchronous active-high reset
//   en_i       per-channel run enable (level)
//   sync_i     one-cycle request to restart every enabled channel at phase 0
//   cfg_we_i   divisor write strobe
//   cfg_ch_i   target channel of the write (out-of-range writes are dropped)
//   cfg_div_i  new divisor; 0 and 1 behave as 2
//   clk_o      registered divided clock per channel
//   tick_o     registered one-cycle pulse per period per channel
//   pend_o     a written divisor is waiting for the next period boundary
module azadi_clkdiv_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 28,
  parameter int DIV_RST = 6000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_act_q;
    logic [CNT_W-1:0] div_pend_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] d_last;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_d;
    logic             run;
    logic             wr;
    logic             wrap;
    logic             commit;

    always_comb begin
      d      = (div_act_q < TWO) ? TWO : div_act_q;
      d_last = d - ONE;
      half   = d >> 1;
      run    = en_i[c];
      wr     = cfg_we_i && (cfg_ch_i == CH_W'(c));
      wrap   = run && (cnt_q >= d_last);
      // Divisor only changes at a period boundary, when idle,
      // or on a phase-align; a same-cycle write bypasses div_pend.
      commit = (pend_q || wr) && (wrap || !run || sync_i);
      div_d  = wr ? cfg_div_i : div_pend_q;
      cnt_d  = (!run || sync_i || wrap) ? '0 : cnt_q + ONE;
    end

    always_ff @(posedge clock) begin
      if (reset_i) begin
        cnt_q      <= '0;
        div_act_q  <= DIV_INIT;
        div_pend_q <= DIV_INIT;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        clk_q  <= run && (cnt_q < half);
        // A period cut short by sync_i does not tick.
        tick_q <= wrap && !sync_i;
        pend_q <= !commit && (pend_q || wr);
        if (wr)
          div_pend_q <= cfg_div_i;
        if (commit)
          div_act_q <= div_d;
      end
    end

    assign clk_o[c]  = clk_q;
    assign tick_o[c] = tick_q;
    assign pend_o[c] = pend_q;
  end

endmodule

// File: tb/tb_azadi_clkdiv_bank.sv
// Scoreboard bench for azadi_clkdiv_bank: driver pushes model
// expectations, monitor pops and compares after every clock edge.
module tb_azadi_clkdiv_bank;

  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 8;
  localparam int DIV_RST = 7;
  localparam int CH_W    = 3;
  localparam int VW      = 3 * NUM_CH;

  logic              clock = 1'b0;
  logic              reset_i;
  logic [NUM_CH-1:0] en_i;
  logic              sync_i;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [CNT_W-1:0]  cfg_div_i;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] pend_o;

  always #5 clock = ~clock;

  azadi_clkdiv_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DIV_RST(DIV_RST)
  ) dut (
    .clock    (clock),
    .reset_i  (reset_i),
    .en_i     (en_i),
    .sync_i   (sync_i),
    .cfg_we_i (cfg_we_i),
    .cfg_ch_i (cfg_ch_i),
    .cfg_div_i(cfg_div_i),
    .clk_o    (clk_o),
    .tick_o   (tick_o),
    .pend_o   (pend_o)
  );

  int m_cnt [NUM_CH];
  int m_act [NUM_CH];
  int m_pv  [NUM_CH];
  bit m_pf  [NUM_CH];

  logic [VW-1:0] exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string tag    = "reset";

  task automatic model_step(input bit r, input logic [NUM_CH-1:0] en,
                            input bit s, input bit we,
                            input int ch, input int dv);
    logic [NUM_CH-1:0] ck;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] pd;
    ck = '0;
    tk = '0;
    pd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r) begin
        m_cnt[c] = 0;
        m_act[c] = DIV_RST;
        m_pv[c]  = DIV_RST;
        m_pf[c]  = 1'b0;
      end else begin
        int d;
        bit wrap;
        d     = (m_act[c] < 2) ? 2 : m_act[c];
        wrap  = en[c] && (m_cnt[c] >= d - 1);
        ck[c] = en[c] && (m_cnt[c] < d / 2);
        tk[c] = wrap && !s;
        if (we && ch == c) begin
          m_pv[c] = dv;
          m_pf[c] = 1'b1;
        end
        if (m_pf[c] && (!en[c] || wrap || s)) begin
          m_act[c] = m_pv[c];
          m_pf[c]  = 1'b0;
        end
        m_cnt[c] = (!en[c] || s || wrap) ? 0 : m_cnt[c] + 1;
        pd[c] = m_pf[c];
      end
    end
    exp_q.push_back({ck, tk, pd});
  endtask

  task automatic drive(input bit r, input logic [NUM_CH-1:0] en,
                       input bit s, input bit we,
                       input int ch, input int dv);
    @(negedge clock);
    reset_i   = r;
    en_i      = en;
    sync_i    = s;
    cfg_we_i  = we;
    cfg_ch_i  = CH_W'(ch);
    cfg_div_i = CNT_W'(dv);
    model_step(r, en, s, we, ch, dv);
  endtask

  task automatic run(input int n, input logic [NUM_CH-1:0] en);
    repeat (n) drive(1'b0, en, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wait_cnt(input int c, input int v,
                          input logic [NUM_CH-1:0] en);
    int k;
    k = 0;
    while (m_cnt[c] != v && k < 64) begin
      drive(1'b0, en, 1'b0, 1'b0, 0, 0);
      k++;
    end
    if (m_cnt[c] != v) begin
      checks++;
      errors++;
      $display("FAIL %s wait_cnt ch%0d got %0d want %0d",
               tag, c, m_cnt[c], v);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        logic [VW-1:0] e;
        logic [VW-1:0] a;
        e = exp_q.pop_front();
        a = {clk_o, tick_o, pend_o};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s t=%0t clk/tick/pend got %b_%b_%b want %b_%b_%b",
                   tag, $time,
                   a[VW-1 -: NUM_CH], a[2*NUM_CH-1 -: NUM_CH],
                   a[NUM_CH-1:0],
                   e[VW-1 -: NUM_CH], e[2*NUM_CH-1 -: NUM_CH],
                   e[NUM_CH-1:0]);
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] en_r;
    reset_i   = 1'b1;
    en_i      = '0;
    sync_i    = 1'b0;
    cfg_we_i  = 1'b0;
    cfg_ch_i  = '0;
    cfg_div_i = '0;

    tag = "reset";
    drive(1'b1, '1, 1'b1, 1'b1, 0, 10);
    drive(1'b1, '1, 1'b0, 1'b0, 0, 0);

    tag = "rst_release";
    run(20, 5'b00001);

    tag = "div4";
    drive(1'b0, 5'b00001, 1'b0, 1'b1, 0, 4);
    run(16, 5'b00001);

    tag = "div5";
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 1, 5);
    run(20, 5'b00011);
    tag = "div0";
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 1, 0);
    run(10, 5'b00011);
    tag = "div1";
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 1, 1);
    run(10, 5'b00011);

    tag = "late_write";
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 0, 8);
    run(6, 5'b00011);
    wait_cnt(0, 2, 5'b00011);
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 0, 3);
    run(12, 5'b00011);
    tag = "wrap_write";
    wait_cnt(0, 2, 5'b00011);
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 0, 6);
    run(14, 5'b00011);

    tag = "sync";
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 0, 4);
    drive(1'b0, 5'b00011, 1'b0, 1'b1, 1, 6);
    run(15, 5'b00011);
    drive(1'b0, 5'b00011, 1'b1, 1'b0, 0, 0);
    run(14, 5'b00011);
    tag = "sync_write";
    drive(1'b0, 5'b00011, 1'b1, 1'b1, 1, 9);
    run(20, 5'b00011);

    tag = "en_drop";
    drive(1'b0, 5'b00111, 1'b0, 1'b1, 2, 9);
    run(4, 5'b00111);
    drive(1'b0, 5'b00111, 1'b0, 1'b1, 2, 3);
    drive(1'b0, 5'b00011, 1'b0, 1'b0, 0, 0);
    run(10, 5'b00111);

    tag = "reset_mid";
    drive(1'b0, 5'b00111, 1'b0, 1'b1, 0, 10);
    drive(1'b1, 5'b00111, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 5'b00111, 1'b0, 1'b1, 5, 3);
    drive(1'b0, 5'b00111, 1'b0, 1'b1, 7, 2);
    run(20, 5'b00111);

    tag  = "random";
    en_r = '1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0)
        en_r = NUM_CH'($urandom);
      drive($urandom_range(0, 199) == 0, en_r,
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 12)));
    end

    tag = "drain";
    @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s queue got %0d left want 0", tag, exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
